// File: rtl/pmem_port_scheduler.sv
// ============================================================================
// pmem_port_scheduler
// ----------------------------------------------------------------------------
// Shares the single L2 request port between the instruction cache (port A)
// and the data cache (port B). One request is granted at a time; the granted
// port's address, write data and operation are latched, so requester input
// changes during service have no effect. Port B has fixed priority, but once
// B has been granted STARVE_LIMIT times in a row while A was waiting, A wins
// the next decision.
//
// Optional feature (macro ARB_PERF_COUNT_EN):
//   defined     - conflict_count counts IDLE decisions where both ports
//                 request, saturating at 16'hFFFF, cleared only by rst.
//   not defined - conflict_count is tied to zero and no counter is built.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   pmem_read_a/_write_a          port A request (held until pmem_resp_a)
//   pmem_address_a/_wdata_a       port A line address / writeback data
//   pmem_resp_a/_rdata_a          port A completion strobe / read data
//   pmem_*_b                      same set for port B
//   l2_read/_write                downstream request
//   l2_address/_wdata             downstream address / write data
//   l2_resp/_rdata                downstream completion / read data
//   conflict_count                performance counter (see above)
// ============================================================================
module pmem_port_scheduler #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         pmem_read_a,
    input  logic         pmem_write_a,
    input  logic [15:0]  pmem_address_a,
    input  logic [255:0] pmem_wdata_a,
    output logic         pmem_resp_a,
    output logic [255:0] pmem_rdata_a,

    input  logic         pmem_read_b,
    input  logic         pmem_write_b,
    input  logic [15:0]  pmem_address_b,
    input  logic [255:0] pmem_wdata_b,
    output logic         pmem_resp_b,
    output logic [255:0] pmem_rdata_b,

    output logic         l2_read,
    output logic         l2_write,
    output logic [15:0]  l2_address,
    output logic [255:0] l2_wdata,
    input  logic         l2_resp,
    input  logic [255:0] l2_rdata,

    output logic [15:0]  conflict_count
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [3:0]     starve_reg, starve_next;
    logic [15:0]    addr_reg, addr_next;
    logic [255:0]   wdata_reg, wdata_next;
    logic           write_reg, write_next;

    logic           req_a, req_b;
    logic           grant_a, grant_b;

    assign req_a = pmem_read_a | pmem_write_a;
    assign req_b = pmem_read_b | pmem_write_b;

    // ------------------------------------------------------------------
    // State and request latches
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            starve_reg <= 4'd0;
            addr_reg   <= 16'd0;
            wdata_reg  <= 256'd0;
            write_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            starve_reg <= starve_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            write_reg  <= write_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, grant decision and latch loading
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        starve_next = starve_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        write_next  = write_reg;
        grant_a     = 1'b0;
        grant_b     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req_a && req_b) begin
                    // B normally wins; A wins once B has starved it enough.
                    if (starve_reg == STARVE_MAX) begin
                        grant_a = 1'b1;
                    end else begin
                        grant_b = 1'b1;
                    end
                end else if (req_a) begin
                    grant_a = 1'b1;
                end else if (req_b) begin
                    grant_b = 1'b1;
                end

                // The count only grows when B beats a waiting A, and the
                // decision above never lets B win at STARVE_MAX, so the
                // counter cannot pass the limit.
                if (grant_a || !req_a) begin
                    starve_next = 4'd0;
                end else if (grant_b) begin
                    starve_next = starve_reg + 4'd1;
                end

                if (grant_a) begin
                    state_next = SERVE_A;
                    addr_next  = pmem_address_a;
                    wdata_next = pmem_wdata_a;
                    write_next = pmem_write_a;   // read+write is a write
                end else if (grant_b) begin
                    state_next = SERVE_B;
                    addr_next  = pmem_address_b;
                    wdata_next = pmem_wdata_b;
                    write_next = pmem_write_b;
                end
            end

            SERVE_A, SERVE_B: begin
                // Always pass through IDLE after a response so a requester
                // that drops its request one cycle late is not re-granted.
                if (l2_resp) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic serving;
    assign serving = (state_reg == SERVE_A) || (state_reg == SERVE_B);

    assign l2_read    = serving && !write_reg;
    assign l2_write   = serving &&  write_reg;
    assign l2_address = addr_reg;
    assign l2_wdata   = wdata_reg;

    assign pmem_resp_a  = (state_reg == SERVE_A) && l2_resp;
    assign pmem_resp_b  = (state_reg == SERVE_B) && l2_resp;
    assign pmem_rdata_a = l2_rdata;
    assign pmem_rdata_b = l2_rdata;

    // ------------------------------------------------------------------
    // Optional conflict counter
    // ------------------------------------------------------------------
`ifdef ARB_PERF_COUNT_EN
    logic [15:0] conflict_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_reg <= 16'd0;
        end else if ((state_reg == IDLE) && req_a && req_b &&
                     (conflict_reg != 16'hFFFF)) begin
            conflict_reg <= conflict_reg + 16'd1;
        end
    end

    assign conflict_count = conflict_reg;
`else
    assign conflict_count = 16'h0000;
`endif

endmodule

// File: doc/pmem_port_scheduler.md
# pmem_port_scheduler

Two-port scheduler that shares the single L2 request port between the instruction cache (port A) and the data cache (port B) miss/writeback interfaces. Sits between both L1 caches and the L2 cache. Requests are granted one at a time and the granted request is latched. Fixed data-side priority is bounded by a starvation limit that guarantees instruction-fetch progress.

## Interface
- STARVE_LIMIT, default 4: consecutive B grants made while A was waiting, after which A is granted next; legal range 1..15.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pmem_read_a / pmem_write_a  in  1 each  port A line read / writeback request; held until pmem_resp_a.
- pmem_address_a  in  16 (lc3b_pmem_addr)  port A line address.
- pmem_wdata_a  in  256 (lc3b_pmem_line)  port A writeback data.
- pmem_resp_a  out  1  port A completion strobe.
- pmem_rdata_a  out  256  port A read data; valid only with pmem_resp_a.
- pmem_read_b, pmem_write_b, pmem_address_b, pmem_wdata_b, pmem_resp_b, pmem_rdata_b: same as port A, for port B.
- l2_read / l2_write  out  1 each  downstream request to L2.
- l2_address  out  16  downstream line address.
- l2_wdata  out  256  downstream write data.
- l2_resp  in  1  L2 completion strobe.
- l2_rdata  in  256  L2 read data.
- conflict_count  out  16  performance counter; see Configuration.

## Operation
- States: IDLE, SERVE_A, SERVE_B. Reset state is IDLE.
- Decision in IDLE:
  - Neither port requests: stay IDLE.
  - Only one port requests: grant that port.
  - Both request: grant B, unless starve_cnt == STARVE_LIMIT, in which case grant A.
- On grant, latch the granted port's address, wdata and op (write if pmem_write_x, else read) into a request register. Next state is SERVE_x.
- A requester asserting read and write together is treated as a write.
- starve_cnt (4-bit):
  - Increments when B is granted while A is requesting.
  - Clears when A is granted, or when A is not requesting at a decision.
  - Never exceeds STARVE_LIMIT.
- In SERVE_x:
  - l2_read / l2_write driven from the latched op; l2_address and l2_wdata driven from the latches.
  - Changes on the requester inputs during SERVE are ignored.
- On l2_resp in SERVE_x:
  - pmem_resp_x = 1 in the same cycle (combinational).
  - pmem_rdata_x = l2_rdata.
  - Next state is IDLE.
- pmem_rdata_a and pmem_rdata_b both continuously equal l2_rdata. Consumers qualify it with resp.
- The non-granted port's resp is always 0.
- Requesters deassert their request the cycle after they receive resp. The mandatory IDLE cycle after every transaction prevents a duplicate grant.
- Reset mid-transaction returns to IDLE, drops l2_read/l2_write, and abandons the transaction. L2 is reset in the same domain.

## Timing
- Reset values:
  - l2_read, l2_write, pmem_resp_a, pmem_resp_b: 0.
  - l2_address, l2_wdata, request latches, starve_cnt, conflict_count: 0.
- Request seen in IDLE at edge N: l2_read or l2_write is asserted from cycle N+1.
- l2_resp in cycle M: requester resp in cycle M. The FSM is in IDLE at M+1, and the earliest next downstream request is M+2.
- Scheduler overhead per transaction is 2 cycles (grant plus IDLE bubble).
- A transaction stalls indefinitely while l2_resp stays low. There is no timeout.
- If a request arrives in the same cycle as l2_resp for the other port, it is considered in the following IDLE cycle.

## Configuration
- `ARB_PERF_COUNT_EN` defined:
  - conflict_count increments by 1 on every IDLE decision where both ports request.
  - Saturates at 16'hFFFF; cleared only by rst.
  - Intended for the memory-mapped counter block.
- Not defined: conflict_count is tied to 16'h0000 and no counter flops are built. Scheduling behaviour is identical in both builds.

## Test plan
- Single A read, addr 16'h1000: l2_read=1 at cycle 1 with l2_address=16'h1000. l2_resp with rdata 256'hABCD at cycle 5 gives pmem_resp_a=1 in cycle 5 and pmem_rdata_a=256'hABCD. State is IDLE at cycle 6.
- Simultaneous A read 16'h2000 and B write 16'h3000 (wdata 256'h55): B is served first, with l2_write=1 and l2_wdata=256'h55. A is served after B's resp plus the IDLE cycle. With ARB_PERF_COUNT_EN, conflict_count=1.
- STARVE_LIMIT=4, A held continuously, B re-requesting back-to-back: B is granted exactly 4 times, then A is granted, then starve_cnt=0.
- Port B changes address from 16'h3000 to 16'h4000 mid-SERVE_B: l2_address stays 16'h3000 until resp.
- rst asserted during SERVE_A: l2_read=0 immediately (asynchronous reset), state IDLE, conflict_count=0.
- Port A asserts read and write together, addr 16'h0040: l2_write=1, l2_read=0.
